ram_reader: RTL

//  Read-side companion of the sample RAM writer. Tracks write strobes on the RAM's

---
 rtl/ram_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_reader
//  Description : Follows write strobes into the dual-port sample RAM, fetches
//                each written word in write order and streams it out as four
//                LANE_W samples over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int LANE_W     = 16,
    parameter int ADDR_MIN   = 1,
    parameter int ADDR_MAX   = 'h3FFF,
    parameter int START_ADDR = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    output logic [ADDR_W-1:0] o_rd_address,
    output logic              o_rd_en,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [LANE_W-1:0] o_sample,
    output logic              o_sample_valid,
    input  logic              i_sample_ready,
    output logic [ADDR_W-1:0] o_level,
    output logic              o_overflow
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_SHIFT = 2'd3;

    localparam logic [ADDR_W-1:0] c_ADDR_MIN   = ADDR_W'(ADDR_MIN);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX   = ADDR_W'(ADDR_MAX);
    localparam logic [ADDR_W-1:0] c_START_ADDR = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] c_DEPTH      = ADDR_W'(ADDR_MAX - ADDR_MIN + 1);
    localparam logic [1:0]        c_WAIT_INIT  = 2'(RD_LATENCY - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_wait;
    logic [1:0]        r_lane;
    logic [DATA_W-1:0] r_hold;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_level;
    logic              r_overflow;

    logic              w_rd;
    logic              w_full;
    logic [ADDR_W-1:0] w_ptr_next;

    assign w_rd       = (r_state == c_ISSUE);
    assign w_full     = (r_level == c_DEPTH);
    assign w_ptr_next = (r_ptr == c_ADDR_MAX) ? c_ADDR_MIN : r_ptr + 1'b1;

    assign o_rd_en        = w_rd;
    assign o_rd_address   = r_ptr;
    assign o_level        = r_level;
    assign o_overflow     = r_overflow;
    assign o_sample_valid = (r_state == c_SHIFT);

    always_comb begin
        o_sample = r_hold[LANE_W-1:0];
        case (r_lane)
            2'd1:    o_sample = r_hold[2*LANE_W-1:LANE_W];
            2'd2:    o_sample = r_hold[3*LANE_W-1:2*LANE_W];
            2'd3:    o_sample = r_hold[4*LANE_W-1:3*LANE_W];
            default: o_sample = r_hold[LANE_W-1:0];
        endcase
    end

    // A write into a full ring drops the oldest word by stepping the read pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= c_START_ADDR;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_wr_en && !w_rd) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_level <= r_level + 1'b1;
                end
            end else if (!i_wr_en && w_rd) begin
                r_level <= r_level - 1'b1;
            end
            if (w_rd || (i_wr_en && w_full)) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_IDLE;
            r_wait  <= 2'd0;
            r_lane  <= 2'd0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (r_level != '0) begin
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_wait  <= c_WAIT_INIT;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (r_wait == 2'd0) begin
                        r_hold  <= i_rd_data;
                        r_lane  <= 2'd0;
                        r_state <= c_SHIFT;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                c_SHIFT: begin
                    if (i_sample_ready) begin
                        if (r_lane == 2'd3) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
